// File: rtl/req_grant_arbiter.sv
// ============================================================================
// Module : req_grant_arbiter
// Eight-requester arbiter with a registered one-hot grant, a watchdog-forced
// release, and fixed priority (bit 7 highest). Defining ARB_ROUND_ROBIN_EN
// selects round-robin priority instead.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module req_grant_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       idle,
  output logic       timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_win;
  logic             w_take;

  assign w_take = (r_state == ST_IDLE) && (req != 8'h00);

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] r_last_id;

  // Search downward from last_id-1; the previous owner (offset 8) is searched last.
  always_comb begin
    w_win = 3'd0;
    for (int s = 8; s >= 1; s--) begin
      if (req[r_last_id - 3'(s)]) w_win = r_last_id - 3'(s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_id <= 3'd0;
    end else if (w_take) begin
      r_last_id <= w_win;
    end
  end
`else
  always_comb begin
    w_win = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) w_win = 3'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      gnt     <= 8'h00;
      gnt_id  <= 3'd0;
      idle    <= 1'b1;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state <= ST_GRANT;
            r_cnt   <= '0;
            gnt     <= 8'h01 << w_win;
            gnt_id  <= w_win;
            idle    <= 1'b0;
          end
        end
        ST_GRANT: begin
          // done has priority over the watchdog at the same edge
          if (done || (r_cnt == c_cnt_last)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            gnt     <= 8'h00;
            gnt_id  <= 3'd0;
            idle    <= 1'b1;
            timeout <= ~done;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          gnt     <= 8'h00;
          gnt_id  <= 3'd0;
          idle    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_req_grant_arbiter.sv
// ============================================================================
// Module : tb_req_grant_arbiter
// Self-checking bench for req_grant_arbiter: directed checks plus random
// traffic compared every cycle against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_req_grant_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       idle;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  req_grant_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .idle    (idle),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = none) and cycles the grant has been visible
  int m_owner = -1;
  int m_hold  = 0;
  bit m_to    = 0;
`ifdef ARB_ROUND_ROBIN_EN
  int m_last  = 0;
`endif

  function automatic int pick(input logic [7:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int s = 1; s <= 8; s++) begin
      if (r[(m_last - s + 8) % 8]) return (m_last - s + 8) % 8;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1;
      m_hold  = 0;
      m_to    = 0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last  = 0;
`endif
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        if (req != 8'h00) begin
          m_owner = pick(req);
          m_hold  = 1;
`ifdef ARB_ROUND_ROBIN_EN
          m_last  = m_owner;
`endif
        end
      end else if (done) begin
        m_owner = -1;
      end else if (m_hold == TIMEOUT) begin
        m_owner = -1;
        m_to    = 1;
      end else begin
        m_hold++;
      end
    end
    #1;
    chk("model_gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
    chk("model_gnt_id", int'(gnt_id), (m_owner < 0) ? 0 : m_owner);
    chk("model_idle", int'(idle), (m_owner < 0) ? 1 : 0);
    chk("model_timeout", int'(timeout), int'(m_to));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ids [9];
    int exp_ids [9];
    int dp;

    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    step();
    step();
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_idle", int'(idle), 1);
    rst_n = 1'b1;
    step();

    // Fixed priority pick, then release gap and next pick
    req = 8'b0100_1001;
    step();
    chk("prio_gnt", int'(gnt), 'h40);
    chk("prio_id", int'(gnt_id), 6);
    chk("prio_idle", int'(idle), 0);
    done = 1'b1;
    req  = 8'b0000_1001;
    step();
    chk("gap_gnt", int'(gnt), 0);
    done = 1'b0;
    step();
    chk("second_gnt", int'(gnt), 'h08);
    chk("second_id", int'(gnt_id), 3);
    done = 1'b1;
    req  = 8'h00;
    step();
    done = 1'b0;

    // Hold without preemption
    req = 8'h01;
    step();
    chk("hold_gnt0", int'(gnt), 'h01);
    req = 8'h81;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_gnt", int'(gnt), 'h01);
    end
    done = 1'b1;
    step();
    chk("hold_release", int'(gnt), 0);
    done = 1'b0;
    step();
    chk("after_hold_gnt", int'(gnt), 'h80);
    done = 1'b1;
    req  = 8'h00;
    step();
    done = 1'b0;

    // Watchdog: grant visible for exactly TIMEOUT cycles
    req = 8'h04;
    step();
    chk("to_gnt_first", int'(gnt), 'h04);
    for (int i = 2; i <= TIMEOUT; i++) begin
      step();
      chk("to_gnt_held", int'(gnt), 'h04);
      chk("to_no_pulse", int'(timeout), 0);
    end
    step();
    chk("to_gnt_released", int'(gnt), 0);
    chk("to_pulse", int'(timeout), 1);
    step();
    chk("to_pulse_end", int'(timeout), 0);
    chk("to_regrant", int'(gnt), 'h04);
    for (int i = 2; i <= TIMEOUT; i++) step();
    done = 1'b1;
    req  = 8'h00;
    step();
    chk("done_beats_to_gnt", int'(gnt), 0);
    chk("done_beats_to_pulse", int'(timeout), 0);

    // Spurious done while idle
    for (int i = 0; i < 6; i++) begin
      done = ~done;
      step();
      chk("spur_idle", int'(idle), 1);
      chk("spur_gnt", int'(gnt), 0);
      chk("spur_to", int'(timeout), 0);
    end
    done = 1'b0;

    // Asynchronous reset in the middle of a grant
    req = 8'h80;
    step();
    chk("pre_rst_gnt", int'(gnt), 'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_id", int'(gnt_id), 0);
    chk("async_rst_idle", int'(idle), 1);
    chk("async_rst_to", int'(timeout), 0);
    step();
    rst_n = 1'b1;

    // Grant sequence with all requesters active
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      done = 1'b0;
      step();
      ids[g] = int'(gnt_id);
      done = 1'b1;
      step();
    end
    done = 1'b0;
    req  = 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
    exp_ids = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
    exp_ids = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
    for (int g = 0; g < 9; g++) chk("seq_id", ids[g], exp_ids[g]);
    step();

    // Random traffic; the second half rarely asserts done so watchdogs fire
    for (int i = 0; i < 4000; i++) begin
      dp   = (i < 2000) ? 3 : 24;
      req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      done = ($urandom_range(0, dp) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
